// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - three-master arbiter in front of the SDRAM controller Avalon-MM slave
module sdram_port_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 16,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic [ADDR_W-1:0] m2_address,
    input  logic              m2_read,
    input  logic              m2_write,
    input  logic [DATA_W-1:0] m2_writedata,
    output logic              m2_waitrequest,
    output logic [DATA_W-1:0] m2_readdata,
    output logic              m2_readdatavalid,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              err_orphan
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        req_rd, req_wr, elig;
    logic [ADDR_W-1:0] p_addr [3];
    logic [DATA_W-1:0] p_data [3];
    logic              fifo_ok, win_valid, accept, push, pop, last_p2;
    logic [1:0]        win, owner, head_id;
    logic [SC_W-1:0]   starve_cnt;
    logic [1:0]        id_mem [MAX_PENDING];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        rdv;
    logic [DATA_W-1:0] rdata;

    assign req_rd    = {m2_read, m1_read, m0_read};
    assign req_wr    = {m2_write, m1_write, m0_write};
    assign p_addr[0] = m0_address;
    assign p_addr[1] = m1_address;
    assign p_addr[2] = m2_address;
    assign p_data[0] = m0_writedata;
    assign p_data[1] = m1_writedata;
    assign p_data[2] = m2_writedata;
    assign fifo_ok   = cnt < CNT_W'(MAX_PENDING);

    // A read wins over a simultaneous write, so a full FIFO blocks that port entirely.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 3; i++) begin
            elig[i] = req_rd[i] ? fifo_ok : req_wr[i];
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win       = 2'd0;
        if (elig[0] && !((starve_cnt >= SC_W'(STARVE_LIMIT)) && (elig[1] || elig[2]))) begin
            win_valid = 1'b1;
        end else if (elig[1] || elig[2]) begin
            win_valid = 1'b1;
            if (last_p2) win = elig[1] ? 2'd1 : 2'd2;
            else         win = elig[2] ? 2'd2 : 2'd1;
        end
    end

    assign accept = (state_q == ISSUE) && !avm_waitrequest;
    assign push   = accept && avm_read;
    assign pop    = avm_readdatavalid && (cnt != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ISSUE;
            ISSUE:   if (!avm_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            owner         <= 2'd0;
            starve_cnt    <= '0;
            last_p2       <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (win_valid) begin
                    avm_address   <= p_addr[win];
                    avm_writedata <= p_data[win];
                    avm_read      <= req_rd[win];
                    avm_write     <= !req_rd[win];
                    owner         <= win;
                end
                if (win_valid && (win != 2'd0)) begin
                    starve_cnt <= '0;
                    last_p2    <= (win == 2'd2);
                end else if (!(elig[1] || elig[2])) begin
                    starve_cnt <= '0;
                end else if (win_valid && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
                    starve_cnt <= starve_cnt + SC_W'(1);
                end
            end else if (!avm_waitrequest) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
        end
    end

    assign m0_waitrequest = !(accept && (owner == 2'd0));
    assign m1_waitrequest = !(accept && (owner == 2'd1));
    assign m2_waitrequest = !(accept && (owner == 2'd2));

    // ID storage needs no reset: validity is tracked by the pointers and count alone.
    always_ff @(posedge clk_clk) begin
        if (push) id_mem[wr_ptr] <= owner;
    end

    assign head_id = id_mem[rd_ptr];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rdv        <= '0;
            rdata      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            rdv <= '0;
            if (pop) begin
                rdv   <= 3'b001 << head_id;
                rdata <= avm_readdata;
            end
            if (avm_readdatavalid && (cnt == '0)) err_orphan <= 1'b1;
        end
    end

    assign m0_readdata      = rdata;
    assign m1_readdata      = rdata;
    assign m2_readdata      = rdata;
    assign m0_readdatavalid = rdv[0];
    assign m1_readdatavalid = rdv[1];
    assign m2_readdatavalid = rdv[2];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [25:0] m0_address, m1_address, m2_address, avm_address;
    logic        m0_read, m1_read, m2_read, m0_write, m1_write, m2_write;
    logic [15:0] m0_writedata, m1_writedata, m2_writedata, avm_writedata;
    logic        m0_waitrequest, m1_waitrequest, m2_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, m2_readdata, avm_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, m2_readdatavalid;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid, err_orphan;

    sdram_port_arbiter dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .m2_address(m2_address), .m2_read(m2_read), .m2_write(m2_write), .m2_writedata(m2_writedata),
        .m2_waitrequest(m2_waitrequest), .m2_readdata(m2_readdata), .m2_readdatavalid(m2_readdatavalid),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .err_orphan(err_orphan)
    );

    initial forever #5 clk_clk = ~clk_clk;

    typedef struct { int port; logic [15:0] data; } sb_t;
    typedef struct { int port; logic [25:0] addr; logic [15:0] data; logic wr; logic [2:0] wq; int cyc; } gnt_t;
    typedef struct { logic [25:0] addr; int cyc; } ctl_t;

    sb_t  sb[$];
    gnt_t glog[$];
    ctl_t cq[$];

    int total = 0, bad = 0, cycle = 0, wr_cycles = 0, rdv_cnt = 0, first_ret = -1, rdv_before;
    logic        b_rd [3], b_wr [3];
    int          b_left [3];
    logic [25:0] b_addr [3];
    logic [15:0] b_wdata [3];
    logic        ret_en = 1'b0, stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs shortly after the rising edge, sample on the falling edge.
    task automatic cyc();
        logic [2:0]  wq, rv;
        logic [15:0] rd [3];
        @(posedge clk_clk);
        cycle++;
        #2;
        m0_read = b_rd[0]; m0_write = b_wr[0]; m0_address = b_addr[0]; m0_writedata = b_wdata[0];
        m1_read = b_rd[1]; m1_write = b_wr[1]; m1_address = b_addr[1]; m1_writedata = b_wdata[1];
        m2_read = b_rd[2]; m2_write = b_wr[2]; m2_address = b_addr[2]; m2_writedata = b_wdata[2];
        avm_waitrequest = stall;
        if (ret_en && cq.size() > 0 && cq[0].cyc + 2 <= cycle) begin
            ctl_t c = cq.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = c.addr[15:0];
            if (first_ret < 0) first_ret = cycle;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 16'hdead;
        end
        @(negedge clk_clk);
        if (avm_write) wr_cycles++;
        if (avm_read && !avm_waitrequest) cq.push_back('{avm_address, cycle});
        wq = {m2_waitrequest, m1_waitrequest, m0_waitrequest};
        rv = {m2_readdatavalid, m1_readdatavalid, m0_readdatavalid};
        rd[0] = m0_readdata; rd[1] = m1_readdata; rd[2] = m2_readdata;
        for (int n = 0; n < 3; n++) begin
            if (!wq[n]) begin
                glog.push_back('{n, avm_address, avm_writedata, avm_write, wq, cycle});
                if (b_rd[n]) sb.push_back('{n, b_addr[n][15:0]});
                b_left[n]--;
                b_addr[n] += 26'd2;
                if (b_left[n] <= 0) begin b_rd[n] = 1'b0; b_wr[n] = 1'b0; end
            end
            if (rv[n]) begin
                rdv_cnt++;
                if (sb.size() == 0) check("rdv_unexpected", 32'(rv), 32'd0);
                else begin
                    sb_t e = sb.pop_front();
                    check("rdv_port", n, e.port);
                    check("rdv_data", 32'(rd[n]), 32'(e.data));
                end
            end
        end
    endtask

    task automatic run_until_grants(input int n, input int budget, input string tag);
        int b = budget;
        while (glog.size() < n && b > 0) begin cyc(); b--; end
        check(tag, glog.size(), n);
    endtask

    task automatic drain(input string tag);
        int b = 60;
        while ((sb.size() > 0 || cq.size() > 0) && b > 0) begin cyc(); b--; end
        repeat (3) cyc();
        check(tag, sb.size(), 0);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            b_rd[n] = 0; b_wr[n] = 0; b_left[n] = 0; b_addr[n] = '0; b_wdata[n] = '0;
        end
        reset_reset_n = 1'b0;
        m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
        m2_read = 0; m2_write = 0; m2_address = '0; m2_writedata = '0;
        avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
        repeat (3) cyc();
        reset_reset_n = 1'b1;
        cyc();

        // reset state
        check("rst_avm_read", 32'(avm_read), 0);
        check("rst_avm_write", 32'(avm_write), 0);
        check("rst_avm_address", 32'(avm_address), 0);
        check("rst_avm_writedata", 32'(avm_writedata), 0);
        check("rst_waitreq", 32'({m2_waitrequest, m1_waitrequest, m0_waitrequest}), 32'b111);
        check("rst_rdv", 32'({m2_readdatavalid, m1_readdatavalid, m0_readdatavalid}), 0);
        check("rst_readdata", 32'(m0_readdata), 0);
        check("rst_err_orphan", 32'(err_orphan), 0);

        // single port-2 write
        glog.delete(); wr_cycles = 0;
        b_wr[2] = 1; b_left[2] = 1; b_addr[2] = 26'h0000100; b_wdata[2] = 16'hBEEF;
        run_until_grants(1, 10, "t1_grants");
        repeat (4) cyc();
        check("t1_write_cycles", wr_cycles, 1);
        if (glog.size() > 0) begin
            check("t1_port", glog[0].port, 2);
            check("t1_addr", 32'(glog[0].addr), 32'h100);
            check("t1_data", 32'(glog[0].data), 32'hBEEF);
            check("t1_waitreq", 32'(glog[0].wq), 32'b011);
        end

        // ports 1 and 2 reading continuously
        glog.delete(); ret_en = 1;
        b_rd[1] = 1; b_left[1] = 4; b_addr[1] = 26'h1111;
        b_rd[2] = 1; b_left[2] = 4; b_addr[2] = 26'h2222;
        run_until_grants(8, 40, "t2_grants");
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check("t2_order", glog[i].port, (i % 2 == 0) ? 1 : 2);
        drain("t2_drain");

        // port-0 starvation guard
        glog.delete();
        b_rd[0] = 1; b_left[0] = 20; b_addr[0] = 26'h0A0A;
        b_rd[1] = 1; b_left[1] = 2;  b_addr[1] = 26'h1500;
        run_until_grants(22, 120, "t3_grants");
        for (int i = 0; i < 22 && i < glog.size(); i++)
            check("t3_order", glog[i].port, (i == 8 || i == 17) ? 1 : 0);
        drain("t3_drain");

        // ID FIFO full blocks the fifth read
        glog.delete(); ret_en = 0;
        b_rd[2] = 1; b_left[2] = 5; b_addr[2] = 26'h2400;
        repeat (20) cyc();
        check("t4_accepted", glog.size(), 4);
        check("t4_m2_wait", 32'(m2_waitrequest), 1);
        check("t4_no_read", 32'(avm_read), 0);
        first_ret = -1; ret_en = 1;
        run_until_grants(5, 30, "t4_fifth");
        if (glog.size() > 4) check("t4_after_pop", 32'(glog[4].cyc > first_ret), 1);
        drain("t4_drain");

        // controller stall during a port-1 write
        glog.delete(); stall = 1;
        b_wr[1] = 1; b_left[1] = 1; b_addr[1] = 26'h1234; b_wdata[1] = 16'h5A5A;
        cyc();
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin b_rd[0] = 1; b_left[0] = 1; b_addr[0] = 26'h0B0B; end
            cyc();
            check("t5_write", 32'(avm_write), 1);
            check("t5_addr", 32'(avm_address), 32'h1234);
            check("t5_data", 32'(avm_writedata), 32'h5A5A);
            check("t5_waitreq", 32'({m2_waitrequest, m1_waitrequest, m0_waitrequest}), 32'b111);
        end
        stall = 0;
        cyc();
        check("t5_accept", 32'({m2_waitrequest, m1_waitrequest, m0_waitrequest}), 32'b101);
        run_until_grants(2, 10, "t5_grants");
        if (glog.size() > 1) check("t5_port0_after", glog[1].port, 0);
        drain("t5_drain");
        check("t5_no_orphan", 32'(err_orphan), 0);

        // reset with reads outstanding
        glog.delete(); ret_en = 0;
        b_rd[0] = 1; b_left[0] = 3; b_addr[0] = 26'h3000;
        run_until_grants(3, 20, "t6_grants");
        reset_reset_n = 1'b0;
        #1;
        check("t6_avm_read", 32'(avm_read), 0);
        check("t6_avm_address", 32'(avm_address), 0);
        check("t6_waitreq", 32'({m2_waitrequest, m1_waitrequest, m0_waitrequest}), 32'b111);
        check("t6_err", 32'(err_orphan), 0);
        for (int n = 0; n < 3; n++) begin b_rd[n] = 0; b_wr[n] = 0; b_left[n] = 0; end
        sb.delete();
        repeat (2) cyc();
        reset_reset_n = 1'b1;
        rdv_before = rdv_cnt; ret_en = 1;
        repeat (12) cyc();
        check("t6_orphan", 32'(err_orphan), 1);
        check("t6_no_rdv", rdv_cnt - rdv_before, 0);
        check("t6_strays_gone", cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller Avalon-MM slave between three masters:
  - port 0: VGA pixel-buffer fetch, latency-critical;
  - port 1: audio sample DMA;
  - port 2: Nios data master.
- Port 0 has fixed top priority with a starvation guard. Ports 1/2 are round-robin.
- Supports pipelined reads with in-order return routing via an ID FIFO.
- Sits between the masters and the SDRAM controller inside the system top level.

Parameters:
ADDR_W, 26, byte address width (64 MB x16 SDRAM)
DATA_W, 16, data width, matches sdram_dq
MAX_PENDING, 4, max outstanding reads (ID FIFO depth, power of 2)
STARVE_LIMIT, 8, consecutive port-0 grants allowed while port 1/2 wait

Ports:
clk_clk  in  1  system clock; the block uses this one clock only
reset_reset_n  in  1  reset, asynchronous assert, active-low
mN_address  in  ADDR_W  requester N address (N=0,1,2, one set per port)
mN_read  in  1  read request, held until accepted
mN_write  in  1  write request, held until accepted
mN_writedata  in  DATA_W  write data
mN_waitrequest  out  1  low for exactly one cycle when command accepted, else high
mN_readdata  out  DATA_W  read data
mN_readdatavalid  out  1  one-cycle strobe for port N's returned word
avm_address  out  ADDR_W  to SDRAM controller
avm_read  out  1  registered read command
avm_write  out  1  registered write command
avm_writedata  out  DATA_W  registered write data
avm_waitrequest  in  1  controller stall
avm_readdata  in  DATA_W  controller read data
avm_readdatavalid  in  1  controller read-data strobe
err_orphan  out  1  sticky: readdatavalid arrived with ID FIFO empty

Behaviour:
- Reset (reset_reset_n low, async):
  - State IDLE. avm_read/avm_write = 0. avm_address/avm_writedata = 0.
  - All mN_waitrequest = 1. All mN_readdatavalid = 0. mN_readdata = 0.
  - ID FIFO empty. Starvation counter = 0. RR pointer = "last granted = port 2", so port 1 wins first.
  - err_orphan = 0.
  - Reset mid-transaction drops the command and all pending read IDs. Masters are reset by the same reset.
- A port is eligible when mN_read or mN_write is high. Eligible reads additionally need FIFO count < MAX_PENDING. Writes are never blocked by the FIFO.
- If mN_read and mN_write are both high, the read is taken and the write is ignored. This is illegal stimulus.
- State IDLE, evaluated every cycle:
  - Select the winner:
    - port 0 if eligible, unless starve_cnt >= STARVE_LIMIT and port 1 or 2 is eligible;
    - otherwise the round-robin choice between 1 and 2, first eligible after the last granted of the pair.
  - Latch the winner's id, address, data and command into avm_* registers.
  - Go to ISSUE.
  - No eligible port: stay in IDLE.
- State ISSUE:
  - avm_read/avm_write asserted, registers held stable while avm_waitrequest = 1.
  - First cycle with avm_waitrequest = 0:
    - command accepted; assert owner's mN_waitrequest = 0 that same cycle (combinational on avm_waitrequest and state);
    - for a read, push the owner id into the ID FIFO;
    - next cycle: avm_read/avm_write = 0, return to IDLE.
- Timing:
  - Request first high in cycle N yields avm command in cycle N+1.
  - With zero controller stall, the grant is in cycle N+1 and the next arbitration is in cycle N+2.
  - Peak throughput is one command per 2 cycles.
- Starvation counter:
  - Increments on each port-0 grant while port 1 or 2 is eligible. Saturates at STARVE_LIMIT.
  - Clears on any port-1/2 grant, and on any cycle in IDLE where neither port 1 nor 2 is eligible.
- RR pointer updates only on port-1/2 grants.
- Read return:
  - On avm_readdatavalid with the FIFO non-empty, pop the head id h and drive mh_readdata = avm_readdata and mh_readdatavalid = 1, registered one cycle after the avm strobe.
  - Returns are strictly in issue order.
  - Push and pop in the same cycle leave the count unchanged; both take effect.
  - avm_readdatavalid with the FIFO empty: data discarded, err_orphan set until reset.
- Write-then-read ordering is guaranteed by issue order; the controller preserves it.
- FIFO pointers wrap modulo MAX_PENDING. The count occupies log2(MAX_PENDING)+1 bits.

Test Plan:
- Single port-2 write, addr 0x0000100, data 0xBEEF, avm_waitrequest low -> avm_write high exactly 1 cycle with addr 0x100 and data 0xBEEF; m2_waitrequest low that cycle; other ports' waitrequest stay high.
- Ports 1 and 2 both reading continuously, controller never stalls -> grants alternate 1,2,1,2, port 1 first after reset; each mN_readdatavalid returns the matching data, e.g. 0x1111 to port 1 and 0x2222 to port 2.
- Port 0 streaming reads plus port 1 read pending, STARVE_LIMIT = 8 -> exactly 8 port-0 grants, then 1 port-1 grant, then port 0 resumes; starve counter back to 0.
- Controller holds readdatavalid low while port 2 issues 5 reads -> 4 accepted; 5th stays unissued with m2_waitrequest high until the first return pops the FIFO; then it issues.
- avm_waitrequest held high for 10 cycles during a port-1 write -> avm_* stable for all 10 cycles; m1_waitrequest low only on cycle 11; a port-0 request arriving mid-stall waits.
- Reset asserted with 3 reads outstanding -> all outputs at reset values immediately; later stray avm_readdatavalid sets err_orphan = 1, no mN_readdatavalid pulses.
